md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit with HI/LO registers for the E stage of the pipelined CPU. It executes the eight HI/LO operations issued by the main control unit's `HILO_Op` and `start` outputs. Multiply and divide have configurable multi-cycle latency, with a `busy` handshake the hazard unit uses to stall D. An exception/interrupt request (`req`) cancels any operation issued in the same cycle.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for mult/multu; must be ≥1.
- `DIV_CYCLES`, 10: busy cycles for div/divu; must be ≥1.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  asserted with a mult/multu/div/divu op.
- `op`  in  4  HILO_Op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none.
- `a`  in  WIDTH  rs operand, already forwarded.
- `b`  in  WIDTH  rt operand, already forwarded.
- `req`  in  1  exception/interrupt taken this cycle; kills this cycle's op.
- `busy`  out  1  a multi-cycle op is in flight.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.
- `out`  out  WIDTH  combinational read: `hi` for op 5, `lo` for op 6, else 0.

## Operation
- Idle, with `start`=1, op∈{1..4} and `req`=0:
  - compute the result into pending registers `phi`/`plo`;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - set `busy`.
- Result rules:
  - mult: signed 2·WIDTH product; HI = upper half, LO = lower half.
  - multu: unsigned product, same split.
  - div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - div overflow (−2^(WIDTH−1) / −1): LO = −2^(WIDTH−1), HI = 0.
  - divu: unsigned quotient and remainder.
  - Division by zero (div/divu): `busy` runs the full DIV_CYCLES, but HI/LO are left unchanged.
- Busy: the counter decrements each cycle. In the cycle the counter is 1, the edge commits `phi`/`plo` to HI/LO (except on divide-by-zero) and clears `busy`.
- mthi/mtlo (ops 7/8) with `req`=0 and not busy: write `a` to HI/LO at the next edge; no busy.
- `req`=1: this cycle's start/mthi/mtlo has no effect. An op already in flight continues and commits; it belongs to an older, already-retired instruction.
- `start` or op 7/8 while `busy`=1: ignored, with no state change. The hazard unit must stall these; the bench checks them as no-ops.
- `start`=1 with op ∉ {1..4}: ignored.
- `start`=0 with op ∈ {1..4}: ignored.

## Timing
- Reset: `busy`=0, `hi`=0, `lo`=0, counter=0, `phi`=`plo`=0. This applies at any time, including mid-operation; the pending result is discarded.
- Start sampled at edge k:
  - `busy`=1 during cycles k+1 … k+N (N = MULT_CYCLES or DIV_CYCLES);
  - new `hi`/`lo` visible from cycle k+N+1, when `busy` has already returned to 0.
- Back-to-back: a start presented in the first cycle with `busy`=0 is accepted. There is no dead cycle.
- mthi/mtlo sampled at edge k: the new value is visible in cycle k+1.
- `out` is purely combinational from the current `hi`/`lo`. An mfhi in the same cycle as an mthi returns the old HI.
- Hazard rule, implemented outside this block: stall D when the D instruction has nonzero HILO_Op and (`start` or `busy`) is true in E.

## Structure
- Shared package `md_pkg`:
  - `MD_NONE`…`MD_MTLO` op-code constants (4-bit), shared with the main control unit;
  - `MD_CNT_W = $clog2(max(MULT_CYCLES, DIV_CYCLES)+1)`.
- Sub-module `md_calc`: purely combinational. Inputs `op`, `a`, `b`; outputs `res_hi`, `res_lo`, `div_zero`.
- Top level (`md_unit`): counter, pending registers, commit logic, `out` mux.

## Test plan
- Signed mult: reset, then `start`, op=1, a=0xFFFFFFFE (−2), b=3 → `busy` for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned mult: op=2, a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 at cycle k+6.
- Signed div: op=3, a=−7, b=2 → `busy` for 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- Div edge cases:
  - op=3, a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0;
  - then op=4, b=0 → 10 busy cycles, HI/LO unchanged.
- Write, read, cancel:
  - op=7 with a=0x12345678 → next cycle `hi`=0x12345678, and op=5 gives `out`=0x12345678;
  - op=8 with `req`=1 → `lo` unchanged.
- Busy and reset handling:
  - a start during `busy` is ignored: the original result commits and the busy length is unchanged;
  - `reset` asserted mid-div → next cycle `busy`=0, HI=LO=0, and no later commit.

Source files
------------

// File: rtl/md_pkg.sv
// Package for the multiply/divide unit.
// Holds the HILO_Op codes shared with the main control unit, the default
// latencies and a helper that sizes the busy counter for a given pair of
// latencies.
package md_pkg;

    // HILO_Op codes; 9..15 decode as "none".
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Counter must hold the larger latency as a value (not as an index).
    function automatic int md_cnt_w(input int mult_cycles, input int div_cycles);
        int mx;
        mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(mx + 1);
    endfunction

    localparam int MD_CNT_W = md_cnt_w(MD_MULT_CYCLES_DEF, MD_DIV_CYCLES_DEF);

endpackage

// File: rtl/md_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
//   start, op, a, b, req : issue side (driven by the pipeline)
//   busy, hi, lo, out    : unit state and mfhi/mflo read port
interface md_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             req;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] out;

    // Pipeline side.
    modport master (
        output start, op, a, b, req,
        input  busy, hi, lo, out
    );

    // Multiply/divide unit side.
    modport slave (
        input  start, op, a, b, req,
        output busy, hi, lo, out
    );
endinterface

// File: rtl/md_calc.sv
// Combinational HI/LO result generator for mult/multu/div/divu.
//   op       : HILO_Op code
//   a, b     : rs / rt operands
//   res_hi   : HI result (product upper half, or remainder)
//   res_lo   : LO result (product lower half, or quotient)
//   div_zero : div/divu with b == 0; the caller must not commit the result
module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    // Multiplying the sign-extended operands gives the signed product modulo
    // 2^(2*WIDTH), so both products use the same unsigned multiplier form.
    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [2*WIDTH-1:0] prod_s, prod_u;

    assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
    assign a_zx   = {{WIDTH{1'b0}}, a};
    assign b_zx   = {{WIDTH{1'b0}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // One unsigned divider serves both div and divu. For div, operands are
    // converted to magnitudes and the signs are reapplied afterwards.
    logic             a_neg, b_neg, is_sdiv;
    logic [WIDTH-1:0] a_mag, b_mag, dvd, dvs, dvs_safe;
    logic [WIDTH-1:0] q_raw, r_raw, q_signed, r_signed;

    assign is_sdiv  = (op == MD_DIV);
    assign a_neg    = a[WIDTH-1];
    assign b_neg    = b[WIDTH-1];
    assign a_mag    = a_neg ? (~a + 1'b1) : a;
    assign b_mag    = b_neg ? (~b + 1'b1) : b;
    assign dvd      = is_sdiv ? a_mag : a;
    assign dvs      = is_sdiv ? b_mag : b;
    // Keep the divider defined on a zero divisor; the result is discarded.
    assign dvs_safe = (dvs == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : dvs;
    assign q_raw    = dvd / dvs_safe;
    assign r_raw    = dvd % dvs_safe;

    // Most-negative / -1: magnitude quotient is 2^(WIDTH-1), which reads back
    // as the most-negative value with remainder 0 -- the required overflow
    // result falls out without a special case.
    assign q_signed = (a_neg ^ b_neg) ? (~q_raw + 1'b1) : q_raw;
    assign r_signed = a_neg ? (~r_raw + 1'b1) : r_raw;

    always_comb begin
        res_hi   = '0;
        res_lo   = '0;
        div_zero = 1'b0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
            end
            MD_DIV: begin
                res_hi   = r_signed;
                res_lo   = q_signed;
                div_zero = (b == '0);
            end
            MD_DIVU: begin
                res_hi   = r_raw;
                res_lo   = q_raw;
                div_zero = (b == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO for the E stage.
// The result is computed at issue into pending registers and committed to
// HI/LO after a fixed latency, while busy holds off dependent instructions.
//   clk, reset   : clock, synchronous active-high reset
//   bus.start    : issue strobe for mult/multu/div/divu
//   bus.op       : HILO_Op code
//   bus.a, bus.b : forwarded rs / rt operands
//   bus.req      : exception/interrupt this cycle; cancels this cycle's op
//   bus.busy     : multi-cycle op in flight
//   bus.hi/lo    : architectural HI / LO
//   bus.out      : combinational mfhi/mflo read
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input logic  clk,
    input logic  reset,
    md_if.slave  bus
);

    localparam int CNT_W = md_cnt_w(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [WIDTH-1:0] res_hi, res_lo;
    logic             div_zero;

    md_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op       (bus.op),
        .a        (bus.a),
        .b        (bus.b),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] phi_q, phi_d;
    logic [WIDTH-1:0] plo_q, plo_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic is_md_op, is_div_op;

    assign is_md_op  = (bus.op == MD_MULT) || (bus.op == MD_MULTU) ||
                       (bus.op == MD_DIV)  || (bus.op == MD_DIVU);
    assign is_div_op = (bus.op == MD_DIV)  || (bus.op == MD_DIVU);

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        phi_d  = phi_q;
        plo_d  = plo_q;
        dz_d   = dz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;

        if (busy_q) begin
            // In flight: new issues and moves are ignored; req does not
            // cancel, since the op belongs to an already-retired instruction.
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                busy_d = 1'b0;
                if (!dz_q) begin
                    hi_d = phi_q;
                    lo_d = plo_q;
                end
            end
        end else if (!bus.req) begin
            if (bus.start && is_md_op) begin
                phi_d  = res_hi;
                plo_d  = res_lo;
                dz_d   = div_zero;
                busy_d = 1'b1;
                cnt_d  = is_div_op ? DIV_LOAD : MULT_LOAD;
            end else if (bus.op == MD_MTHI) begin
                hi_d = bus.a;
            end else if (bus.op == MD_MTLO) begin
                lo_d = bus.a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            phi_q  <= '0;
            plo_q  <= '0;
            dz_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            phi_q  <= phi_d;
            plo_q  <= plo_d;
            dz_q   <= dz_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // Read port sees the registered values, so an mfhi alongside an mthi
    // returns the old HI.
    always_comb begin
        bus.out = '0;
        if (bus.op == MD_MFHI) begin
            bus.out = hi_q;
        end else if (bus.op == MD_MFLO) begin
            bus.out = lo_q;
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a cycle-indexed reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_md_unit;

    localparam int W    = 32;
    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic clk;
    logic reset;

    md_if #(.WIDTH(W)) bus ();

    md_unit #(
        .WIDTH       (W),
        .MULT_CYCLES (MULN),
        .DIV_CYCLES  (DIVN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // State is kept as "last cycle index that is busy" and committed at the
    // edge that closes that cycle; arithmetic uses 64-bit integers.
    int          cyc     = 0;
    int          m_until = -1;
    logic        m_dz    = 1'b0;
    logic [W-1:0] m_phi = '0, m_plo = '0, m_hi = '0, m_lo = '0;

    always @(posedge clk) begin : model
        longint      sp, sa, sb;
        logic [63:0] up;
        if (reset) begin
            m_hi    <= '0;
            m_lo    <= '0;
            m_until <= -1;
            m_dz    <= 1'b0;
        end else if (cyc == m_until) begin
            if (!m_dz) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
        end else if (cyc > m_until && !bus.req) begin
            if (bus.start && bus.op >= 4'd1 && bus.op <= 4'd4) begin
                m_dz    <= 1'b0;
                m_until <= cyc + ((bus.op <= 4'd2) ? MULN : DIVN);
                sa = longint'($signed(bus.a));
                sb = longint'($signed(bus.b));
                case (bus.op)
                    4'd1: begin
                        sp = sa * sb;
                        m_phi <= sp[63:32];
                        m_plo <= sp[31:0];
                    end
                    4'd2: begin
                        up = {32'd0, bus.a} * {32'd0, bus.b};
                        m_phi <= up[63:32];
                        m_plo <= up[31:0];
                    end
                    4'd3: begin
                        if (sb == 0) m_dz <= 1'b1;
                        else begin
                            sp = sa / sb;
                            m_plo <= sp[31:0];
                            sp = sa % sb;
                            m_phi <= sp[31:0];
                        end
                    end
                    default: begin
                        if (bus.b == 0) m_dz <= 1'b1;
                        else begin
                            m_plo <= bus.a / bus.b;
                            m_phi <= bus.a % bus.b;
                        end
                    end
                endcase
            end else if (bus.op == 4'd7) begin
                m_hi <= bus.a;
            end else if (bus.op == 4'd8) begin
                m_lo <= bus.a;
            end
        end
        cyc <= cyc + 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc busy", {31'd0, bus.busy}, {31'd0, (cyc <= m_until)});
            check("cyc hi", bus.hi, m_hi);
            check("cyc lo", bus.lo, m_lo);
            check("cyc out", bus.out,
                  (bus.op == 4'd5) ? m_hi : (bus.op == 4'd6) ? m_lo : '0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic st, input logic [3:0] o,
                         input logic [W-1:0] aa, input logic [W-1:0] bb, input logic rq);
        bus.start = st;
        bus.op    = o;
        bus.a     = aa;
        bus.b     = bb;
        bus.req   = rq;
    endtask

    // Count busy cycles until the first idle cycle; leaves inputs idle.
    task automatic wait_idle(output int n);
        bit done;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (bus.busy) n++;
            else done = 1'b1;
            #1 drive(1'b0, 4'd0, '0, '0, 1'b0);
        end
        if (!done) check("busy timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input string name, input logic st, input logic [3:0] o,
                       input logic [W-1:0] aa, input logic [W-1:0] bb, input logic rq,
                       output int n);
        drive(st, o, aa, bb, rq);
        wait_idle(n);
        $display("[TB] %s: start=%0d op=%0d a=%h b=%h req=%0d busy_cycles=%0d hi=%h lo=%h",
                 name, st, o, aa, bb, rq, n, bus.hi, bus.lo);
    endtask

    int n, n0;

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'd0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        chk_en = 1'b1;
        #1 reset = 1'b0;

        // Signed multiply -2 * 3.
        run("mult", 1'b1, 4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, n);
        check("mult busy len", n, 32'd5);
        check("mult hi", bus.hi, 32'hFFFFFFFF);
        check("mult lo", bus.lo, 32'hFFFFFFFA);

        // Unsigned multiply, issued in the first idle cycle (back-to-back).
        run("multu", 1'b1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, n);
        check("multu busy len", n, 32'd5);
        check("multu hi", bus.hi, 32'hFFFFFFFE);
        check("multu lo", bus.lo, 32'h00000001);

        // Signed divide -7 / 2.
        run("div", 1'b1, 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, n);
        check("div busy len", n, 32'd10);
        check("div lo", bus.lo, 32'hFFFFFFFD);
        check("div hi", bus.hi, 32'hFFFFFFFF);

        // Overflow case.
        run("div ovf", 1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, n);
        check("div ovf lo", bus.lo, 32'h80000000);
        check("div ovf hi", bus.hi, 32'h00000000);

        // Unsigned divide by zero: full latency, HI/LO untouched.
        run("divu by 0", 1'b1, 4'd4, 32'd5, 32'd0, 1'b0, n);
        check("divu0 busy len", n, 32'd10);
        check("divu0 lo", bus.lo, 32'h80000000);
        check("divu0 hi", bus.hi, 32'h00000000);

        // mthi then mfhi.
        drive(1'b0, 4'd7, 32'h12345678, '0, 1'b0);
        @(negedge clk);
        check("mthi hi", bus.hi, 32'h12345678);
        #1 drive(1'b0, 4'd5, '0, '0, 1'b0);
        #1 check("mfhi out", bus.out, 32'h12345678);
        $display("[TB] mthi/mfhi: hi=%h out=%h", bus.hi, bus.out);

        // mtlo cancelled by req, then mflo shows the old LO.
        drive(1'b0, 4'd8, 32'hDEADBEEF, '0, 1'b1);
        @(negedge clk);
        check("mtlo req lo", bus.lo, 32'h80000000);
        #1 drive(1'b0, 4'd6, '0, '0, 1'b0);
        #1 check("mflo out", bus.out, 32'h80000000);
        $display("[TB] mtlo+req/mflo: lo=%h out=%h", bus.lo, bus.out);

        // Cancelled and malformed issues.
        run("mult+req", 1'b1, 4'd1, 32'd2, 32'd3, 1'b1, n);
        check("mult req busy", n, 32'd0);
        check("mult req lo", bus.lo, 32'h80000000);
        run("start op9", 1'b1, 4'd9, 32'd2, 32'd3, 1'b0, n);
        check("op9 busy", n, 32'd0);
        run("op1 nostart", 1'b0, 4'd1, 32'd2, 32'd3, 1'b0, n);
        check("nostart busy", n, 32'd0);
        check("nostart hi", bus.hi, 32'h12345678);

        // Start and mthi during busy are ignored.
        drive(1'b1, 4'd1, 32'd2, 32'd3, 1'b0);
        @(negedge clk);
        n0 = bus.busy ? 1 : 0;
        #1 drive(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        n0 += bus.busy ? 1 : 0;
        #1 drive(1'b0, 4'd7, 32'hFFFF0000, '0, 1'b0);
        wait_idle(n);
        $display("[TB] mult with start/mthi during busy: busy_cycles=%0d hi=%h lo=%h",
                 n0 + n, bus.hi, bus.lo);
        check("busy-ignore len", n0 + n, 32'd5);
        check("busy-ignore hi", bus.hi, 32'h00000000);
        check("busy-ignore lo", bus.lo, 32'h00000006);

        // Reset mid-divide discards the pending result.
        drive(1'b0, 4'd7, 32'h11111111, '0, 1'b0);
        @(negedge clk);
        #1 drive(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
        repeat (3) begin
            @(negedge clk);
            #1 drive(1'b0, 4'd0, '0, '0, 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("midreset busy", {31'd0, bus.busy}, 32'd0);
        check("midreset hi", bus.hi, 32'd0);
        check("midreset lo", bus.lo, 32'd0);
        #1 reset = 1'b0;
        repeat (12) @(negedge clk);
        check("postreset busy", {31'd0, bus.busy}, 32'd0);
        check("postreset hi", bus.hi, 32'd0);
        check("postreset lo", bus.lo, 32'd0);
        $display("[TB] reset mid-div: busy=%0d hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
